// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// mux_scan_ctrl : steps an 8:1 mux select through every channel and
//                 assembles the sampled mux output into a registered byte.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctrl #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] mask_i,
  input  logic              y_i,
  output logic [SEL_W-1:0]  s_o,
  output logic [NUM_CH-1:0] data_out_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  C_WAIT   = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0]  C_LAST   = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [NUM_CH-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   ch_nxt;

  assign ch_nxt = ch_q + SEL_W'(1);

  // Enabled channels dwell in SETTLE first; masked ones (or SETTLE=0) sample at once.
  function automatic state_t slot_entry(input logic en);
    return (en && (SETTLE > 0)) ? ST_SETTLE : ST_SAMPLE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      ch_q     <= '0;
      s_q      <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      ch_q     <= ch_d;
      s_q      <= s_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ch_d     = ch_q;
    s_d      = s_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if ((state_q != ST_IDLE) && abort_i) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      s_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mask_d   = mask_i;
            shadow_d = '0;
            s_d      = '0;
            ch_d     = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            wait_d   = C_WAIT;
            state_d  = slot_entry(mask_i[0]);
          end
        end
        ST_SETTLE: begin
          wait_d = wait_q - CNT_W'(1);
          if (wait_q <= CNT_W'(1)) begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shadow_d[ch_q] = y_i & mask_q[ch_q];
          if (ch_q != C_LAST) begin
            ch_d    = ch_nxt;
            s_d     = ch_nxt;
            wait_d  = C_WAIT;
            state_d = slot_entry(mask_q[ch_nxt]);
          end else begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            s_d     = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign s_o        = s_q;
  assign data_out_o = data_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// tb_mux_scan_ctrl : directed bench for mux_scan_ctrl, SETTLE=1 and SETTLE=0.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] start_v, abort_v, y_v, valid_v, busy_v, done_v;
  logic [7:0]    mask_v [NI];
  logic [7:0]    iv     [NI];
  logic [2:0]    s_v    [NI];
  logic [7:0]    dout_v [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 8:1 mux in front of each instance
  assign y_v[0] = iv[0][s_v[0]];
  assign y_v[1] = iv[1][s_v[1]];

  mux_scan_ctrl #(.NUM_CH(8), .SEL_W(3), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .abort_i(abort_v[0]),
    .mask_i(mask_v[0]), .y_i(y_v[0]), .s_o(s_v[0]), .data_out_o(dout_v[0]),
    .valid_o(valid_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]));

  mux_scan_ctrl #(.NUM_CH(8), .SEL_W(3), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .abort_i(abort_v[1]),
    .mask_i(mask_v[1]), .y_i(y_v[1]), .s_o(s_v[1]), .data_out_o(dout_v[1]),
    .valid_o(valid_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]));

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Model: on start, lay out a per-cycle timeline of which channel is
  // selected; a channel is sampled on the edge that ends its run.
  int         tl [NI][16];
  int         m_len [NI];
  int         m_pos [NI];
  bit         m_busy [NI];
  logic [2:0] m_s [NI];
  logic [7:0] m_mask [NI], m_shadow [NI], m_data [NI];
  logic       m_valid [NI], m_done [NI];
  int         mdl_slot, mdl_ch;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_s[k] = 3'd0; m_data[k] = 8'd0; m_valid[k] = 1'b0;
        m_done[k] = 1'b0; m_shadow[k] = 8'd0; m_pos[k] = 0; m_len[k] = 0;
      end else begin
        m_done[k] = 1'b0;
        if (!m_busy[k]) begin
          if (start_v[k]) begin
            m_len[k] = 0;
            for (int n = 0; n < 8; n++) begin
              mdl_slot = mask_v[k][n] ? settle_of(k) + 1 : 1;
              for (int c = 0; c < mdl_slot; c++) begin
                tl[k][m_len[k]] = n;
                m_len[k]++;
              end
            end
            m_mask[k] = mask_v[k]; m_shadow[k] = 8'd0; m_pos[k] = 0;
            m_busy[k] = 1; m_valid[k] = 1'b0; m_s[k] = 3'(tl[k][0]);
          end
        end else if (abort_v[k]) begin
          m_busy[k] = 0; m_s[k] = 3'd0;
        end else begin
          mdl_ch = tl[k][m_pos[k]];
          if (m_pos[k] == m_len[k] - 1 || tl[k][m_pos[k] + 1] != mdl_ch)
            m_shadow[k][mdl_ch] = iv[k][mdl_ch] & m_mask[k][mdl_ch];
          m_pos[k]++;
          if (m_pos[k] == m_len[k]) begin
            m_data[k] = m_shadow[k]; m_valid[k] = 1'b1; m_done[k] = 1'b1;
            m_busy[k] = 0; m_s[k] = 3'd0;
          end else begin
            m_s[k] = 3'(tl[k][m_pos[k]]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("s", k, 32'(s_v[k]), 32'(m_s[k]));
      chk("data_out", k, 32'(dout_v[k]), 32'(m_data[k]));
      chk("valid", k, 32'(valid_v[k]), 32'(m_valid[k]));
      chk("busy", k, 32'(busy_v[k]), 32'(m_busy[k]));
      chk("done", k, 32'(done_v[k]), 32'(m_done[k]));
    end
  end

  // Pulses start across edge E0; returns at the negedge just after E0.
  task automatic start_scan(input int k, input logic [7:0] m);
    start_v[k] = 1'b1;
    mask_v[k]  = m;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // cnt counts negedges since start was raised; done after E0+L shows at cnt=L+1.
  task automatic wait_done(input int k, input int c0, output int lat, output int vlow);
    int cnt;
    cnt  = c0;
    vlow = 0;
    while (!done_v[k] && cnt < 200) begin
      if (!valid_v[k]) vlow++;
      @(negedge clk);
      cnt++;
    end
    if (!done_v[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout[%0d] waiting for done", k);
    end
    lat = cnt - 1;
  endtask

  task automatic count_done(input int k, input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_v[k]) nd++;
    end
  endtask

  initial begin
    int lat, vl, nd;
    start_v = '0; abort_v = '0;
    for (int k = 0; k < NI; k++) begin mask_v[k] = 8'h00; iv[k] = 8'h00; end
    repeat (3) @(negedge clk);
    chk("rst_s", 0, 32'(s_v[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_valid", 1, 32'(valid_v[1]), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full scan, SETTLE=1
    iv[0] = 8'hA5;
    start_scan(0, 8'hFF);
    wait_done(0, 1, lat, vl);
    chk("full_lat", 0, lat, 16);
    chk("full_data", 0, 32'(dout_v[0]), 32'hA5);
    chk("full_busy", 0, 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);

    // Masked scan
    iv[0] = 8'hFF;
    start_scan(0, 8'h0F);
    wait_done(0, 1, lat, vl);
    chk("mask_lat", 0, lat, 12);
    chk("mask_data", 0, 32'(dout_v[0]), 32'h0F);
    repeat (3) @(negedge clk);

    // Zero settle, back-to-back start in the done cycle
    iv[1] = 8'h3C;
    start_scan(1, 8'hFF);
    wait_done(1, 1, lat, vl);
    chk("z_lat1", 1, lat, 8);
    chk("z_data1", 1, 32'(dout_v[1]), 32'h3C);
    iv[1] = 8'hC3;
    start_scan(1, 8'hFF);
    wait_done(1, 1, lat, vl);
    chk("z_lat2", 1, lat, 8);
    chk("z_vlow", 1, vl, 8);
    chk("z_data2", 1, 32'(dout_v[1]), 32'hC3);
    repeat (3) @(negedge clk);

    // Start while busy is ignored
    iv[0] = 8'h96;
    start_scan(0, 8'hFF);
    @(negedge clk); @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, 6, lat, vl);
    chk("busy_start_lat", 0, lat, 16);
    chk("busy_start_data", 0, 32'(dout_v[0]), 32'h96);
    count_done(0, 20, nd);
    chk("busy_start_ndone", 0, nd, 0);

    // Abort
    iv[0] = 8'h5A;
    start_scan(0, 8'hFF);
    wait_done(0, 1, lat, vl);
    chk("abort_pre_data", 0, 32'(dout_v[0]), 32'h5A);
    @(negedge clk);
    iv[0] = 8'hA5;
    start_scan(0, 8'hFF);
    repeat (5) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("abort_s", 0, 32'(s_v[0]), 32'd0);
    count_done(0, 20, nd);
    chk("abort_ndone", 0, nd, 0);
    chk("abort_data", 0, 32'(dout_v[0]), 32'h5A);
    chk("abort_valid", 0, 32'(valid_v[0]), 32'd0);

    // Asynchronous reset mid-scan
    iv[0] = 8'h77;
    start_scan(0, 8'hFF);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_s", 0, 32'(s_v[0]), 32'd0);
    chk("arst_data", 0, 32'(dout_v[0]), 32'd0);
    chk("arst_valid", 0, 32'(valid_v[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("arst_done", 0, 32'(done_v[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    iv[0] = 8'h81;
    start_scan(0, 8'hFF);
    wait_done(0, 1, lat, vl);
    chk("post_rst_lat", 0, lat, 16);
    chk("post_rst_data", 0, 32'(dout_v[0]), 32'h81);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
